sar_afe_emu: RTL and testbench
==============================

SAR_AFE_EMU -- requirements
Module: sar_afe_emu

Interface
REQ-001 Parameter: Width, default 6, converter resolution in bits.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 vin_i  input  Width  emulated analog input code, unsigned.
REQ-005 offset_i  input  3  comparator offset, two's complement, range -4..+3.
REQ-006 lat_i  input  2  extra comparator latency, 0..3 cycles.
REQ-007 sample_i  input  1  sample command from the SAR controller; high = track.
REQ-008 dac_i  input  Width  DAC trial code from the SAR controller.
REQ-009 eoc_i  input  1  end-of-conversion strobe from the SAR controller.
REQ-010 result_i  input  Width  conversion result from the SAR controller, valid with eoc_i.
REQ-011 cmp_o  output  1  comparator decision to the SAR controller.
REQ-012 held_o  output  Width  held sample (before offset).
REQ-013 busy_o  output  1  high in TRACK, CONV or CHECK.
REQ-014 match_o  output  1  one-cycle pulse in CHECK when result_i equals the expected code.
REQ-015 conv_cnt_o  output  8  completed conversions, saturating.
REQ-016 err_cnt_o  output  8  mismatched conversions, saturating.

Function
REQ-017 States: IDLE, TRACK, CONV, CHECK; encoding is free.
REQ-018 IDLE: sample_i=1 -> TRACK; otherwise stay; eoc_i is ignored.
REQ-019 TRACK: held loads vin_i every cycle; sample_i=0 -> CONV with held frozen at the last loaded value.
REQ-020 CONV: eoc_i=1 -> CHECK, registering result_i; sample_i=1 (abort) -> TRACK with no count change; sample_i takes priority over eoc_i.
REQ-021 CHECK lasts exactly one cycle, then -> IDLE; sample_i in CHECK is honoured in the next IDLE cycle.
REQ-022 Effective level heff = held + sign-extended offset_i, computed at Width+2 bits and saturated to 0..2^Width-1.
REQ-023 Expected result = heff.
REQ-024 cmp_raw = (heff >= dac_i) in CONV; cmp_raw = 0 in all other states.
REQ-025 cmp_raw feeds a 4-stage shift register; cmp_o = stage lat_i (stage 0 = one register), so total latency is 1+lat_i cycles.
REQ-026 lat_i changes take effect on the tap immediately; pipeline contents are not flushed.
REQ-027 In CHECK: match_o=1 if registered result == heff, otherwise 0.
REQ-028 In CHECK: conv_cnt_o increments; err_cnt_o increments on mismatch; both hold at 255.
REQ-029 match_o is 0 in every state except CHECK.
REQ-030 busy_o = (state != IDLE), registered with the state.

Reset
REQ-031 rst_i=1 forces state IDLE; held_o, cmp_o, match_o, busy_o, conv_cnt_o, err_cnt_o, the cmp pipeline and the result register clear to 0.
REQ-032 Reset has priority over every other input and aborts TRACK, CONV or CHECK without counting.

Verification
REQ-033 Reset: rst_i=1 for 2 cycles with random inputs -> all outputs 0 and busy_o=0 on the next edge.
REQ-034 Nominal, Width=6, offset 0, lat 0, vin 45: sample_i high 2 cycles then low; dac 32 -> cmp_o=1 next cycle; dac 48 -> cmp_o=0; eoc_i with result 45 -> match_o pulses; conv_cnt_o=1; err_cnt_o=0.
REQ-035 Saturation: offset -3 with vin 2 -> heff 0, dac 0 gives cmp_o=1, result 0 matches; offset +3 with vin 62 -> heff 63, result 62 gives match_o=0 and err_cnt_o=1.
REQ-036 Latency: lat_i=3, held 45, dac steps 50->40 in CONV -> cmp_o rises exactly 4 cycles after the step.
REQ-037 Abort and simultaneous events: sample_i and eoc_i both high in CONV -> TRACK, no match_o pulse, counts unchanged; rst_i mid-CONV -> IDLE, counts 0.
REQ-038 Saturation of counters: 256 mismatching conversions -> conv_cnt_o=255, err_cnt_o=255, both stable thereafter.

Source files
------------

// File: rtl/sar_afe_emu.sv
// sar_afe_emu: behavioural emulation of a SAR ADC analog front end.
// Tracks and holds an input code, applies a comparator offset, answers DAC
// trial comparisons with programmable latency, and scores each conversion
// result from the external SAR controller against the ideal code.
module sar_afe_emu #(
    parameter int unsigned Width = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] vin_i,
    input  logic [2:0]       offset_i,
    input  logic [1:0]       lat_i,
    input  logic             sample_i,
    input  logic [Width-1:0] dac_i,
    input  logic             eoc_i,
    input  logic [Width-1:0] result_i,
    output logic             cmp_o,
    output logic [Width-1:0] held_o,
    output logic             busy_o,
    output logic             match_o,
    output logic [7:0]       conv_cnt_o,
    output logic [7:0]       err_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_CONV,
        S_CHECK
    } state_t;

    state_t             state_q, state_d;
    logic [Width-1:0]   held_q, held_d;
    logic [Width-1:0]   res_q, res_d;
    logic [3:0]         pipe_q, pipe_d;
    logic               busy_q, busy_d;
    logic [7:0]         conv_cnt_q, conv_cnt_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic signed [Width+1:0] level_sum;
    logic [Width-1:0]        heff;
    logic                    cmp_raw;
    logic                    res_ok;

    // Offset-shifted hold level, clamped to the converter code range.
    always_comb begin
        level_sum = $signed({2'b00, held_q})
                  + $signed({{(Width-1){offset_i[2]}}, offset_i});
        if (level_sum[Width+1]) begin
            heff = '0;
        end else if (level_sum[Width]) begin
            heff = '1;
        end else begin
            heff = level_sum[Width-1:0];
        end
        cmp_raw = (state_q == S_CONV) && (heff >= dac_i);
        res_ok  = (res_q == heff);
    end

    // Next-state, hold/result capture, comparator pipeline and scoring counters.
    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        res_d      = res_q;
        pipe_d     = {pipe_q[2:0], cmp_raw};
        conv_cnt_d = conv_cnt_q;
        err_cnt_d  = err_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (sample_i) state_d = S_TRACK;
            end
            S_TRACK: begin
                held_d = vin_i;
                if (!sample_i) state_d = S_CONV;
            end
            S_CONV: begin
                if (sample_i) begin
                    state_d = S_TRACK;
                end else if (eoc_i) begin
                    res_d   = result_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (conv_cnt_q != 8'hFF) conv_cnt_d = conv_cnt_q + 8'd1;
                if (!res_ok && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            held_q     <= '0;
            res_q      <= '0;
            pipe_q     <= '0;
            busy_q     <= 1'b0;
            conv_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            res_q      <= res_d;
            pipe_q     <= pipe_d;
            busy_q     <= busy_d;
            conv_cnt_q <= conv_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign cmp_o      = pipe_q[lat_i];
    assign held_o     = held_q;
    assign busy_o     = busy_q;
    assign match_o    = (state_q == S_CHECK) && res_ok;
    assign conv_cnt_o = conv_cnt_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_sar_afe_emu.sv
// tb_sar_afe_emu: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the front end.
module tb_sar_afe_emu;

    localparam int W    = 6;
    localparam int MAXC = (1 << W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_TRACK = 1;
    localparam int M_CONV  = 2;
    localparam int M_CHECK = 3;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [W-1:0] vin_i;
    logic [2:0]   offset_i;
    logic [1:0]   lat_i;
    logic         sample_i;
    logic [W-1:0] dac_i;
    logic         eoc_i;
    logic [W-1:0] result_i;
    logic         cmp_o;
    logic [W-1:0] held_o;
    logic         busy_o;
    logic         match_o;
    logic [7:0]   conv_cnt_o;
    logic [7:0]   err_cnt_o;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state
    int m_state;
    int m_held;
    int m_res;
    int m_conv;
    int m_err;
    bit m_hist [4];   // m_hist[k]: comparator decision made k+1 cycles ago

    // Outputs observed at the last negedge
    logic         obs_cmp, obs_busy, obs_match;
    logic [W-1:0] obs_held;
    logic [7:0]   obs_conv, obs_err;

    sar_afe_emu #(.Width(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .vin_i      (vin_i),
        .offset_i   (offset_i),
        .lat_i      (lat_i),
        .sample_i   (sample_i),
        .dac_i      (dac_i),
        .eoc_i      (eoc_i),
        .result_i   (result_i),
        .cmp_o      (cmp_o),
        .held_o     (held_o),
        .busy_o     (busy_o),
        .match_o    (match_o),
        .conv_cnt_o (conv_cnt_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_heff();
        int off;
        int h;
        off = (offset_i >= 3'd4) ? int'(offset_i) - 8 : int'(offset_i);
        h   = m_held + off;
        if (h < 0) h = 0;
        if (h > MAXC) h = MAXC;
        return h;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_held  = 0;
        m_res   = 0;
        m_conv  = 0;
        m_err   = 0;
        for (int k = 0; k < 4; k++) m_hist[k] = 1'b0;
    endtask

    task automatic model_step();
        int  h;
        bit  raw;
        if (rst_i) begin
            model_reset();
            return;
        end
        h   = model_heff();
        raw = (m_state == M_CONV) && (h >= int'(dac_i));
        for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = raw;
        case (m_state)
            M_IDLE: if (sample_i) m_state = M_TRACK;
            M_TRACK: begin
                m_held = int'(vin_i);
                if (!sample_i) m_state = M_CONV;
            end
            M_CONV: begin
                if (sample_i) begin
                    m_state = M_TRACK;
                end else if (eoc_i) begin
                    m_res   = int'(result_i);
                    m_state = M_CHECK;
                end
            end
            default: begin
                if (m_conv < 255) m_conv++;
                if (m_res != h && m_err < 255) m_err++;
                m_state = M_IDLE;
            end
        endcase
    endtask

    // One clock: sample and score outputs at negedge, advance model, settle past posedge.
    task automatic cycle();
        int h;
        @(negedge clk);
        obs_cmp   = cmp_o;
        obs_held  = held_o;
        obs_busy  = busy_o;
        obs_match = match_o;
        obs_conv  = conv_cnt_o;
        obs_err   = err_cnt_o;
        h = model_heff();
        check_eq("cmp_o",      int'(obs_cmp),   int'(m_hist[lat_i]));
        check_eq("held_o",     int'(obs_held),  m_held);
        check_eq("busy_o",     int'(obs_busy),  int'(m_state != M_IDLE));
        check_eq("match_o",    int'(obs_match), int'(m_state == M_CHECK && m_res == h));
        check_eq("conv_cnt_o", int'(obs_conv),  m_conv);
        check_eq("err_cnt_o",  int'(obs_err),   m_err);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input int d, input bit e, input int r);
        sample_i = s;
        dac_i    = W'(d);
        eoc_i    = e;
        result_i = W'(r);
        cycle();
    endtask

    // Full conversion: IDLE->TRACK->CONV->CHECK->IDLE, then observe counters.
    task automatic convert(input int v, input int off, input int res);
        vin_i    = W'(v);
        offset_i = 3'(off);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, res);
        drive(0, 0, 0, 0);
    endtask

    initial begin
        rst_i    = 1'b1;
        vin_i    = '0;
        offset_i = '0;
        lat_i    = '0;
        sample_i = 1'b0;
        dac_i    = '0;
        eoc_i    = 1'b0;
        result_i = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset held for two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            vin_i    = W'($urandom);
            offset_i = 3'($urandom);
            lat_i    = 2'($urandom);
            sample_i = 1'($urandom);
            dac_i    = W'($urandom);
            eoc_i    = 1'($urandom);
            result_i = W'($urandom);
            cycle();
        end
        rst_i    = 1'b0;
        lat_i    = 2'd0;
        offset_i = 3'd0;
        drive(0, 0, 0, 0);
        check_eq("rst_busy", int'(obs_busy), 0);
        check_eq("rst_cmp",  int'(obs_cmp),  0);
        check_eq("rst_held", int'(obs_held), 0);
        check_eq("rst_conv", int'(obs_conv), 0);
        check_eq("rst_err",  int'(obs_err),  0);

        // Nominal conversion of 45
        vin_i = W'(45);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 32, 0, 0);
        drive(0, 48, 0, 0);
        check_eq("nom_cmp_hi", int'(obs_cmp), 1);
        drive(0, 48, 0, 0);
        check_eq("nom_cmp_lo", int'(obs_cmp), 0);
        drive(0, 48, 1, 45);
        drive(0, 0, 0, 0);
        check_eq("nom_match", int'(obs_match), 1);
        drive(0, 0, 0, 0);
        check_eq("nom_conv", int'(obs_conv), 1);
        check_eq("nom_err",  int'(obs_err),  0);

        // Low-side saturation: heff clamps to 0
        vin_i    = W'(2);
        offset_i = 3'b101;
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        check_eq("satlo_cmp", int'(obs_cmp), 1);
        drive(0, 0, 0, 0);
        check_eq("satlo_match", int'(obs_match), 1);
        // High-side saturation: heff clamps to 63, result 62 mismatches
        convert(62, 3, 62);
        check_eq("sathi_match", int'(obs_match), 0);
        drive(0, 0, 0, 0);
        check_eq("sathi_err",  int'(obs_err),  1);
        check_eq("sathi_conv", int'(obs_conv), 3);

        // Comparator latency 3: decision change visible 4 cycles after DAC step
        offset_i = 3'd0;
        lat_i    = 2'd3;
        vin_i    = W'(45);
        drive(1, 50, 0, 0);
        drive(0, 50, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 50, 0, 0);
        drive(0, 40, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 40, 0, 0);
            check_eq("lat3_cmp", int'(obs_cmp), (i == 4) ? 1 : 0);
        end

        // Abort with simultaneous eoc: back to TRACK, no scoring
        drive(1, 40, 1, 45);
        drive(1, 40, 0, 0);
        check_eq("abort_busy",  int'(obs_busy),  1);
        check_eq("abort_match", int'(obs_match), 0);
        check_eq("abort_conv",  int'(obs_conv),  3);
        drive(0, 40, 0, 0);
        drive(0, 40, 0, 0);
        // Reset mid-conversion
        rst_i = 1'b1;
        drive(0, 40, 1, 45);
        rst_i = 1'b0;
        drive(0, 40, 0, 0);
        check_eq("rstconv_busy", int'(obs_busy), 0);
        check_eq("rstconv_conv", int'(obs_conv), 0);

        // Counter saturation after 256 mismatches
        lat_i = 2'd0;
        for (int i = 0; i < 256; i++) convert(10, 0, 11);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            check_eq("sat_conv", int'(obs_conv), 255);
            check_eq("sat_err",  int'(obs_err),  255);
        end
        convert(10, 0, 11);
        drive(0, 0, 0, 0);
        check_eq("sat_conv_hold", int'(obs_conv), 255);
        check_eq("sat_err_hold",  int'(obs_err),  255);

        // Randomized traffic
        rst_i = 1'b1;
        drive(0, 0, 0, 0);
        rst_i = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst_i    = ($urandom_range(0, 99) == 0);
            vin_i    = W'($urandom);
            if ($urandom_range(0, 7) == 0) offset_i = 3'($urandom);
            if ($urandom_range(0, 15) == 0) lat_i = 2'($urandom);
            result_i = ($urandom_range(0, 1) == 0) ? W'(model_heff()) : W'($urandom);
            drive($urandom_range(0, 3) == 0, int'($urandom_range(0, MAXC)),
                  $urandom_range(0, 2) == 0, int'(result_i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
